// File: rtl/gene_net_pkg.sv
// ---------------------------------------------------------------------------
// gene_net_pkg
//   Shared definitions for the gene-network attractor controller:
//   state width, counter width and the sequencer state encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package gene_net_pkg;

  localparam int GN_W     = 8;
  localparam int GN_CNT_W = 9;   // holds 256 (cycle length of a full 8-bit ring)

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LAM  = 3'd1,
    ST_REW  = 3'd2,
    ST_ADV  = 3'd3,
    ST_MU   = 3'd4,
    ST_DONE = 3'd5
  } gn_state_t;

endpackage

// File: rtl/gene_sweep_counter.sv
// ---------------------------------------------------------------------------
// gene_sweep_counter
//   Initial-state generator for sweep builds (macro GENE_SWEEP_EN).
//   Produces x0 = 0..255, advancing once per accepted result and wrapping
//   back to 0 after the last one. Synchronous reset returns it to 0.
//   Ports:
//     clk      in  1  system clock
//     rst      in  1  synchronous active-high reset
//     advance  in  1  step to the next initial state
//     value    out W  current initial state
//   Compiled to an empty file when GENE_SWEEP_EN is undefined.
// ---------------------------------------------------------------------------
`ifdef GENE_SWEEP_EN
module gene_sweep_counter
  import gene_net_pkg::*;
#(
  parameter int W = GN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  output logic [W-1:0] value
);

  // Sweep position register.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= {W{1'b0}};
    end else if (advance) begin
      value <= value + W'(1);
    end else begin
      value <= value;
    end
  end

endmodule
`endif

// File: rtl/gene_net_attractor_ctrl.sv
// ---------------------------------------------------------------------------
// gene_net_attractor_ctrl
//   Drives an external gene-network update function f() to classify the
//   attractor reached from an initial state. Brent's method finds the cycle
//   length (lam), then a two-pointer walk finds the transient length (mu)
//   and the first state on the attractor.
//   Ports:
//     clk        in   1      system clock
//     rst        in   1      synchronous active-high reset
//     start      in   1      run request, sampled only in IDLE
//     init_val   in   W      initial state, captured with start
//     busy       out  1      run in progress / result not yet accepted
//     step_x     out  W      state presented to f()
//     step_fx    in   W      f(step_x), same cycle
//     res_valid  out  1      result valid, held until res_ready
//     res_ready  in   1      result consumer ready
//     res_init   out  W      initial state of this result
//     res_fixed  out  1      1 = fixed point (lam == 1)
//     res_attr   out  W      first state on the attractor
//     res_mu     out  CNT_W  transient length
//     res_lam    out  CNT_W  cycle length
//     sweep_last out  1      (GENE_SWEEP_EN only) result belongs to x0 = 255
//   Configuration macro: GENE_SWEEP_EN -- start sweeps x0 = 0..255 and
//   ignores init_val; undefined builds run once per start.
// ---------------------------------------------------------------------------
module gene_net_attractor_ctrl
  import gene_net_pkg::*;
#(
  parameter int W     = GN_W,
  parameter int CNT_W = GN_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     init_val,
  output logic             busy,
  output logic [W-1:0]     step_x,
  input  logic [W-1:0]     step_fx,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_init,
  output logic             res_fixed,
  output logic [W-1:0]     res_attr,
  output logic [CNT_W-1:0] res_mu,
  output logic [CNT_W-1:0] res_lam
`ifdef GENE_SWEEP_EN
  ,
  output logic             sweep_last
`endif
);

  gn_state_t        state_r;
  logic [W-1:0]     x0_r;
  logic [W-1:0]     tort_r;
  logic [W-1:0]     hare_r;
  logic [CNT_W-1:0] power_r;
  logic [CNT_W-1:0] lam_r;
  logic [CNT_W-1:0] k_r;
  logic [CNT_W-1:0] mu_r;
  logic             sub_r;     // MU phase: 0 = tortoise step, 1 = hare step

  logic             go_s;
  logic [W-1:0]     seed_s;
  logic             handshake_s;

  assign handshake_s = (state_r == ST_DONE) && res_valid && res_ready;

`ifdef GENE_SWEEP_EN
  logic         sweep_run_r;
  logic [W-1:0] sweep_val_s;

  gene_sweep_counter #(.W(W)) u_sweep (
    .clk     (clk),
    .rst     (rst),
    .advance (handshake_s),
    .value   (sweep_val_s)
  );

  // A sweep keeps re-launching itself from IDLE until the last x0 is accepted.
  assign go_s   = start || sweep_run_r;
  assign seed_s = sweep_val_s;
`else
  assign go_s   = start;
  assign seed_s = init_val;
`endif

  // Select which pointer is fed to the external update function this cycle.
  always_comb begin
    step_x = {W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (go_s) begin
          step_x = seed_s;
        end else begin
          step_x = {W{1'b0}};
        end
      end
      ST_LAM:  step_x = hare_r;
      ST_ADV:  step_x = hare_r;
      ST_MU: begin
        if (sub_r) begin
          step_x = hare_r;
        end else begin
          step_x = tort_r;
        end
      end
      default: step_x = {W{1'b0}};
    endcase
  end

  // Sequencer: Brent search, rewind, hare lead-out, mu walk, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      x0_r      <= {W{1'b0}};
      tort_r    <= {W{1'b0}};
      hare_r    <= {W{1'b0}};
      power_r   <= {CNT_W{1'b0}};
      lam_r     <= {CNT_W{1'b0}};
      k_r       <= {CNT_W{1'b0}};
      mu_r      <= {CNT_W{1'b0}};
      sub_r     <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_init  <= {W{1'b0}};
      res_fixed <= 1'b0;
      res_attr  <= {W{1'b0}};
      res_mu    <= {CNT_W{1'b0}};
      res_lam   <= {CNT_W{1'b0}};
`ifdef GENE_SWEEP_EN
      sweep_run_r <= 1'b0;
      sweep_last  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            x0_r    <= seed_s;
            tort_r  <= seed_s;
            hare_r  <= step_fx;           // f(x0)
            power_r <= CNT_W'(1);
            lam_r   <= CNT_W'(1);
            busy    <= 1'b1;
            state_r <= ST_LAM;
`ifdef GENE_SWEEP_EN
            sweep_run_r <= 1'b1;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LAM: begin
          if (tort_r == hare_r) begin
            state_r <= ST_REW;
          end else begin
            // Reset-to-zero then +1 collapses into loading 1.
            if (power_r == lam_r) begin
              tort_r  <= hare_r;
              power_r <= power_r << 1;
              lam_r   <= CNT_W'(1);
            end else begin
              lam_r   <= lam_r + CNT_W'(1);
            end
            hare_r <= step_fx;
          end
        end
        ST_REW: begin
          tort_r  <= x0_r;
          hare_r  <= x0_r;
          k_r     <= {CNT_W{1'b0}};
          state_r <= ST_ADV;
        end
        ST_ADV: begin
          if (k_r == lam_r) begin
            mu_r    <= {CNT_W{1'b0}};
            sub_r   <= 1'b0;
            state_r <= ST_MU;
          end else begin
            hare_r <= step_fx;
            k_r    <= k_r + CNT_W'(1);
          end
        end
        ST_MU: begin
          // Compare only between pairs: mid-pair the pointers are one step
          // out of phase and a fixed point would match spuriously.
          if (!sub_r && (tort_r == hare_r)) begin
            res_valid <= 1'b1;
            res_init  <= x0_r;
            res_fixed <= (lam_r == CNT_W'(1));
            res_attr  <= tort_r;
            res_mu    <= mu_r;
            res_lam   <= lam_r;
`ifdef GENE_SWEEP_EN
            sweep_last <= (x0_r == {W{1'b1}});
`endif
            state_r   <= ST_DONE;
          end else if (!sub_r) begin
            tort_r <= step_fx;
            sub_r  <= 1'b1;
          end else begin
            hare_r <= step_fx;
            mu_r   <= mu_r + CNT_W'(1);
            sub_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          if (handshake_s) begin
            res_valid <= 1'b0;
            state_r   <= ST_IDLE;
`ifdef GENE_SWEEP_EN
            busy <= sweep_run_r && !sweep_last;
            if (sweep_last) begin
              sweep_run_r <= 1'b0;
            end else begin
              sweep_run_r <= sweep_run_r;
            end
`else
            busy <= 1'b0;
`endif
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
